dmem_load_ctrl: RTL and testbench

DMEM_LOAD_CTRL -- requirements
Module: dmem_load_ctrl

---
 rtl/dmem_load_ctrl_pkg.sv | 31 +++
 rtl/dmem_load_ctrl_load_align.sv | 36 +++
 rtl/dmem_load_ctrl.sv | 116 +++++++++++
 tb/tb_dmem_load_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_load_ctrl_pkg.sv
// Shared load-control codes and small decode helpers for the data-memory load path.
// Any module that decodes alucontrol load codes imports this package.
package dmem_load_ctrl_pkg;

    localparam logic [5:0] LB_CONTROL  = 6'b100000;
    localparam logic [5:0] LH_CONTROL  = 6'b100001;
    localparam logic [5:0] LW_CONTROL  = 6'b100011;
    localparam logic [5:0] LBU_CONTROL = 6'b100100;
    localparam logic [5:0] LHU_CONTROL = 6'b100101;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic [1:0] load_size(input logic [5:0] ctrl);
        case (ctrl)
            LB_CONTROL, LBU_CONTROL: return SIZE_BYTE;
            LH_CONTROL, LHU_CONTROL: return SIZE_HALF;
            default:                 return SIZE_WORD;
        endcase
    endfunction

    function automatic logic load_misaligned(input logic [5:0] ctrl, input logic [1:0] lsb);
        case (ctrl)
            LH_CONTROL, LHU_CONTROL: return lsb[0];
            LW_CONTROL:              return |lsb;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ctrl_load_align.sv
// Picks the addressed byte/half out of the bus read word and sign/zero extends it.
module load_align
    import dmem_load_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [5:0]  alucontrol,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr)
            2'b01:   w_byte = rdata[15:8];
            2'b10:   w_byte = rdata[23:16];
            2'b11:   w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        case (alucontrol)
            LB_CONTROL:  result = {{24{w_byte[7]}}, w_byte};
            LBU_CONTROL: result = {24'b0, w_byte};
            LH_CONTROL:  result = {{16{w_half[15]}}, w_half};
            LHU_CONTROL: result = {16'b0, w_half};
            default:     result = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_load_ctrl.sv
// MEM-stage load controller: issues one bus read per aligned load, stalls the
// pipe until data returns, and discards data for loads flushed after acceptance.
module dmem_load_ctrl
    import dmem_load_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        loadM,
    input  logic [5:0]  alucontrolM,
    input  logic [31:0] addressM,
    input  logic        flushM,
    output logic        data_req,
    output logic [31:0] data_addr,
    output logic [1:0]  data_size,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] readdataM,
    output logic        laddrerrM,
    output logic        stallreq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_discard;
    logic        r_req;
    logic [31:0] r_addr;
    logic [5:0]  r_ctrl;
    logic [1:0]  r_size;
    logic [31:0] r_rdata;
    logic        w_start;
    logic [31:0] w_aligned;

    assign laddrerrM = loadM & load_misaligned(alucontrolM, addressM[1:0]);
    assign w_start   = (r_state == S_IDLE) & loadM & ~laddrerrM & ~flushM;
    // Start cycle stalls combinationally; resetn gates it so reset forces 0.
    assign stallreq  = resetn & (w_start | (r_state == S_REQ) | (r_state == S_WAIT));

    assign data_req  = r_req;
    assign data_addr = r_addr;
    assign data_size = r_size;
    assign readdataM = r_rdata;

    load_align u_align (
        .rdata      (data_rdata),
        .addr       (r_addr[1:0]),
        .alucontrol (r_ctrl),
        .result     (w_aligned)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_discard <= 1'b0;
            r_req     <= 1'b0;
            r_addr    <= 32'b0;
            r_ctrl    <= 6'b0;
            r_size    <= 2'b0;
            r_rdata   <= 32'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_REQ;
                        r_req     <= 1'b1;
                        r_discard <= 1'b0;
                        r_addr    <= addressM;
                        r_ctrl    <= alucontrolM;
                        r_size    <= load_size(alucontrolM);
                    end
                end
                S_REQ: begin
                    if (data_addr_ok) begin
                        r_req <= 1'b0;
                        if (data_data_ok) begin
                            if (flushM) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_rdata <= w_aligned;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_state   <= S_WAIT;
                            r_discard <= flushM;
                        end
                    end else if (flushM) begin
                        // Not yet accepted by the bus, so it can simply be withdrawn.
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (r_discard | flushM) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rdata <= w_aligned;
                            r_state <= S_DONE;
                        end
                    end else if (flushM) begin
                        r_discard <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_load_ctrl.sv
// Bench for dmem_load_ctrl: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_dmem_load_ctrl;
    import dmem_load_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        loadM = 1'b0;
    logic [5:0]  alucontrolM = LB_CONTROL;
    logic [31:0] addressM = 32'b0;
    logic        flushM = 1'b0;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'b0;
    logic        data_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic [31:0] readdataM;
    logic        laddrerrM;
    logic        stallreq;

    dmem_load_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .loadM        (loadM),
        .alucontrolM  (alucontrolM),
        .addressM     (addressM),
        .flushM       (flushM),
        .data_req     (data_req),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .readdataM    (readdataM),
        .laddrerrM    (laddrerrM),
        .stallreq     (stallreq)
    );

    always #5 clk = ~clk;

    int n_cyc = 0, n_cyc_fail = 0;
    int n_lit = 0, n_lit_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: one outstanding load described by plain flags.
    bit          m_active, m_acc, m_disc, m_done;
    logic [31:0] m_addr, m_rd;
    logic [5:0]  m_ctrl;
    logic [1:0]  m_size;

    function automatic int differs(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
            return 1;
        end
        return 0;
    endfunction

    function automatic logic [31:0] exp_align(input logic [5:0] c, input logic [1:0] a, input logic [31:0] d);
        logic [31:0]        v;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        v  = d >> (8 * a);
        sb = v[7:0];
        sh = v[15:0];
        if (c == LB_CONTROL)  return 32'(sb);
        if (c == LBU_CONTROL) return {24'b0, v[7:0]};
        if (c == LH_CONTROL)  return 32'(sh);
        if (c == LHU_CONTROL) return {16'b0, v[15:0]};
        return d;
    endfunction

    function automatic logic [1:0] exp_size(input logic [5:0] c);
        if (c == LB_CONTROL || c == LBU_CONTROL) return 2'd0;
        if (c == LH_CONTROL || c == LHU_CONTROL) return 2'd1;
        return 2'd2;
    endfunction

    function automatic bit exp_err();
        return loadM && ((((alucontrolM == LH_CONTROL) || (alucontrolM == LHU_CONTROL)) && addressM[0])
                         || ((alucontrolM == LW_CONTROL) && (addressM[1:0] != 2'b00)));
    endfunction

    function automatic bit exp_start();
        return resetn && loadM && !exp_err() && !flushM && !m_active && !m_done;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0; m_acc <= 1'b0; m_disc <= 1'b0; m_done <= 1'b0;
            m_addr <= 32'b0; m_ctrl <= 6'b0; m_size <= 2'b0; m_rd <= 32'b0;
        end else begin
            m_done <= 1'b0;
            if (exp_start()) begin
                m_active <= 1'b1; m_acc <= 1'b0; m_disc <= 1'b0;
                m_addr <= addressM; m_ctrl <= alucontrolM; m_size <= exp_size(alucontrolM);
            end else if (m_active) begin
                if (!m_acc && !data_addr_ok) begin
                    if (flushM) m_active <= 1'b0;
                end else if (data_data_ok) begin
                    m_active <= 1'b0;
                    if (!(m_disc || flushM)) begin
                        m_rd   <= exp_align(m_ctrl, m_addr[1:0], data_rdata);
                        m_done <= 1'b1;
                    end
                end else begin
                    m_acc <= 1'b1;
                    if (flushM) m_disc <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cyc++; n_cyc_fail += differs("cyc_data_req", 32'(data_req), 32'(m_active && !m_acc));
            n_cyc++; n_cyc_fail += differs("cyc_data_addr", data_addr, m_addr);
            n_cyc++; n_cyc_fail += differs("cyc_data_size", 32'(data_size), 32'(m_size));
            n_cyc++; n_cyc_fail += differs("cyc_readdataM", readdataM, m_rd);
            n_cyc++; n_cyc_fail += differs("cyc_laddrerrM", 32'(laddrerrM), 32'(exp_err()));
            n_cyc++; n_cyc_fail += differs("cyc_stallreq", 32'(stallreq), 32'(resetn && (exp_start() || m_active)));
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_lit++;
        n_lit_fail += differs(name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string name, input logic [5:0] c, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp);
        loadM = 1'b1; alucontrolM = c; addressM = a;
        tick();
        loadM = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = d;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        lit(name, readdataM, exp);
        tick();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        lit("rst_data_req", 32'(data_req), 32'd0);
        lit("rst_data_addr", data_addr, 32'd0);
        lit("rst_readdataM", readdataM, 32'd0);
        lit("rst_stallreq", 32'(stallreq), 32'd0);
        resetn = 1'b1;
        chk_en = 1'b1;

        // LB byte 3, same-cycle accept and data
        loadM = 1'b1; alucontrolM = LB_CONTROL; addressM = 32'h1003;
        #1; lit("lb_stall_start", 32'(stallreq), 32'd1);
        tick();
        loadM = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h80FF_0000;
        #1;
        lit("lb_req", 32'(data_req), 32'd1);
        lit("lb_addr", data_addr, 32'h1003);
        lit("lb_size", 32'(data_size), 32'd0);
        lit("lb_stall_req", 32'(stallreq), 32'd1);
        tick();
        // DONE: a valid load presented here must be ignored
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        loadM = 1'b1; alucontrolM = LBU_CONTROL; addressM = 32'h11;
        #1;
        lit("lb_result", readdataM, 32'hFFFF_FF80);
        lit("done_ignores_load", 32'(stallreq), 32'd0);
        tick();
        lit("idle_restart_stall", 32'(stallreq), 32'd1);
        tick();
        loadM = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0000_FF00;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1; lit("lbu_result", readdataM, 32'h0000_00FF);
        tick();

        // LHU upper half, slow accept and slow data
        loadM = 1'b1; alucontrolM = LHU_CONTROL; addressM = 32'h2002;
        tick();
        loadM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) data_addr_ok = 1'b1;
            #1;
            lit("lhu_req_held", 32'(data_req), 32'd1);
            lit("lhu_addr_held", data_addr, 32'h2002);
            lit("lhu_size", 32'(data_size), 32'd1);
            tick();
        end
        data_addr_ok = 1'b0;
        tick();
        tick();
        data_data_ok = 1'b1; data_rdata = 32'hBEEF_1234;
        #1; lit("lhu_wait_stall", 32'(stallreq), 32'd1);
        tick();
        data_data_ok = 1'b0;
        #1;
        lit("lhu_result", readdataM, 32'h0000_BEEF);
        lit("lhu_done_req", 32'(data_req), 32'd0);
        tick();

        // LW flushed while waiting: data discarded, no DONE
        loadM = 1'b1; alucontrolM = LW_CONTROL; addressM = 32'h4000;
        tick();
        loadM = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0; flushM = 1'b1;
        #1; lit("flushw_stall", 32'(stallreq), 32'd1);
        tick();
        flushM = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        #1; lit("flushw_stall_until_data", 32'(stallreq), 32'd1);
        tick();
        data_data_ok = 1'b0;
        loadM = 1'b1; alucontrolM = LB_CONTROL; addressM = 32'h0;
        #1;
        lit("flushw_kept", readdataM, 32'h0000_BEEF);
        lit("flushw_idle_start", 32'(stallreq), 32'd1);
        tick();
        loadM = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0000_00FE;
        tick();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1; lit("lb_neg_result", readdataM, 32'hFFFF_FFFE);
        tick();

        // misalignment decode (flush held so nothing starts)
        flushM = 1'b1; loadM = 1'b1;
        alucontrolM = LH_CONTROL;  addressM = 32'h1;    #1; lit("err_lh_odd", 32'(laddrerrM), 32'd1);
        alucontrolM = LHU_CONTROL; addressM = 32'h2;    #1; lit("err_lhu_2", 32'(laddrerrM), 32'd0);
        alucontrolM = LB_CONTROL;  addressM = 32'h3;    #1; lit("err_lb_3", 32'(laddrerrM), 32'd0);
        alucontrolM = LW_CONTROL;  addressM = 32'h6;    #1; lit("err_lw_6", 32'(laddrerrM), 32'd1);
        loadM = 1'b0;                                   #1; lit("err_noload", 32'(laddrerrM), 32'd0);
        tick();
        flushM = 1'b0; loadM = 1'b1; alucontrolM = LW_CONTROL; addressM = 32'h3001;
        #1;
        lit("mis_lw_err", 32'(laddrerrM), 32'd1);
        lit("mis_lw_stall", 32'(stallreq), 32'd0);
        tick();
        lit("mis_lw_noreq", 32'(data_req), 32'd0);
        loadM = 1'b0;
        tick();

        do_load("lh_lo_result",  LH_CONTROL,  32'h0, 32'h0000_8001, 32'hFFFF_8001);
        do_load("lbu_b1_result", LBU_CONTROL, 32'h1, 32'h0000_8000, 32'h0000_0080);
        do_load("lb_pos_result", LB_CONTROL,  32'h2, 32'h007F_0000, 32'h0000_007F);
        do_load("lw_result",     LW_CONTROL,  32'h8, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("lh_hi_result",  LH_CONTROL,  32'h2, 32'h8000_0000, 32'hFFFF_8000);

        // flush in REQ before acceptance withdraws the request
        loadM = 1'b1; alucontrolM = LB_CONTROL; addressM = 32'h7;
        tick();
        loadM = 1'b0; flushM = 1'b1;
        tick();
        flushM = 1'b0;
        #1;
        lit("flushr_req", 32'(data_req), 32'd0);
        lit("flushr_stall", 32'(stallreq), 32'd0);
        lit("flushr_kept", readdataM, 32'hFFFF_8000);
        tick();

        // flush coincident with accept+data in REQ: data discarded
        loadM = 1'b1; alucontrolM = LW_CONTROL; addressM = 32'hC;
        tick();
        loadM = 1'b0; flushM = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
        tick();
        flushM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        lit("flushc_kept", readdataM, 32'hFFFF_8000);
        lit("flushc_stall", 32'(stallreq), 32'd0);
        tick();

        // reset during WAIT, then a stale data_ok
        loadM = 1'b1; alucontrolM = LW_CONTROL; addressM = 32'h5000;
        tick();
        loadM = 1'b0; data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #2 resetn = 1'b0;
        #1;
        lit("arst_req", 32'(data_req), 32'd0);
        lit("arst_addr", data_addr, 32'd0);
        lit("arst_size", 32'(data_size), 32'd0);
        lit("arst_stall", 32'(stallreq), 32'd0);
        lit("arst_rdata", readdataM, 32'd0);
        tick();
        resetn = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hAAAA_5555;
        tick();
        data_data_ok = 1'b0;
        #1;
        lit("late_dok_rdata", readdataM, 32'd0);
        lit("late_dok_stall", 32'(stallreq), 32'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_cyc + n_lit, n_cyc_fail + n_lit_fail);
        $finish;
    end

endmodule
